// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared frame geometry, CRC7 polynomial and FSM encodings for the SD CMD-line responder.
package sd_card_cmd_responder_pkg;

  localparam int unsigned FRAME_LEN = 48;
  localparam int unsigned CRC_SPAN  = 40;

  // Bit positions inside a 48-bit frame (MSB transmitted first)
  localparam int unsigned POS_START = 47;
  localparam int unsigned POS_TX    = 46;
  localparam int unsigned IDX_HI    = 45;
  localparam int unsigned IDX_LO    = 40;
  localparam int unsigned ARG_HI    = 39;
  localparam int unsigned ARG_LO    = 8;
  localparam int unsigned CRC_HI    = 7;
  localparam int unsigned CRC_LO    = 1;
  localparam int unsigned POS_END   = 0;

  // G(x) = x^7 + x^3 + 1, x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RECV     = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_WAIT_NCR = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator; clear has priority over enable.
module sd_crc7_serial
  import sd_card_cmd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [6:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit host commands, validates them with CRC7,
// and answers every good non-CMD0 command with an R1 frame after NCR idle cycles.
module sd_card_cmd_responder
  import sd_card_cmd_responder_pkg::*;
#(
  parameter int unsigned NCR = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_from_host,
  input  logic [31:0] card_status,
  output logic        cmd_to_host,
  output logic        cmd_to_host_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_error
);

  localparam logic [5:0] NCR_LAST     = 6'(NCR - 1);
  localparam logic [5:0] RX_LAST      = 6'(FRAME_LEN - 2);
  localparam logic [5:0] RX_CRC_END   = 6'(CRC_SPAN - 1);
  localparam logic [5:0] TX_CRC_START = 6'(CRC_SPAN);
  localparam logic [5:0] TX_END_BIT   = 6'(FRAME_LEN - 1);
  localparam logic [5:0] TX_DONE      = 6'(FRAME_LEN);

  logic [2:0]           state;
  logic                 cmd_in_q;
  // The start bit is implied by entering RECV, so only the remaining 47 bits are stored
  logic [FRAME_LEN-2:0] rx_frame;
  logic [5:0]           rx_cnt;
  logic [5:0]           wait_cnt;
  logic [5:0]           tx_cnt;
  logic [CRC_SPAN-1:0]  tx_shift;
  logic [6:0]           rx_crc;
  logic [6:0]           tx_crc;

  logic rx_crc_clear;
  logic rx_crc_en;
  logic tx_crc_clear;
  logic tx_crc_en;
  logic start_send;
  logic frame_good;
  logic tx_bit;

  assign start_send   = (state == ST_WAIT_NCR) && (wait_cnt == NCR_LAST);
  assign rx_crc_clear = (state == ST_IDLE);
  assign rx_crc_en    = (state == ST_RECV) && (rx_cnt < RX_CRC_END);
  assign tx_crc_clear = (state != ST_WAIT_NCR) && (state != ST_SEND);
  assign tx_crc_en    = start_send || ((state == ST_SEND) && (tx_cnt < TX_CRC_START));

  // Start bit is 0 and leaves a zero CRC unchanged, so feeding begins at the transmission bit
  assign frame_good = rx_frame[POS_TX] && rx_frame[POS_END] &&
                      (rx_crc == rx_frame[CRC_HI:CRC_LO]);

  always_comb begin
    if (tx_cnt < TX_CRC_START) begin
      tx_bit = tx_shift[CRC_SPAN-1];
    end else if (tx_cnt < TX_END_BIT) begin
      tx_bit = tx_crc[3'(TX_END_BIT - 6'd1 - tx_cnt)];
    end else begin
      tx_bit = 1'b1;
    end
  end

  sd_crc7_serial u_rx_crc (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (rx_crc_clear),
    .enable   (rx_crc_en),
    .data_bit (cmd_in_q),
    .crc      (rx_crc)
  );

  sd_crc7_serial u_tx_crc (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (tx_crc_clear),
    .enable   (tx_crc_en),
    .data_bit (tx_shift[CRC_SPAN-1]),
    .crc      (tx_crc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= ST_IDLE;
      cmd_in_q       <= 1'b1;
      rx_frame       <= '0;
      rx_cnt         <= '0;
      wait_cnt       <= '0;
      tx_cnt         <= '0;
      tx_shift       <= '0;
      cmd_to_host    <= 1'b1;
      cmd_to_host_oe <= 1'b0;
      cmd_valid      <= 1'b0;
      crc_error      <= 1'b0;
      cmd_index      <= '0;
      cmd_arg        <= '0;
    end else begin
      cmd_in_q  <= cmd_from_host;
      cmd_valid <= 1'b0;
      crc_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cmd_in_q) begin
            state  <= ST_RECV;
            rx_cnt <= '0;
          end
        end
        ST_RECV: begin
          rx_frame <= {rx_frame[FRAME_LEN-3:0], cmd_in_q};
          rx_cnt   <= rx_cnt + 6'd1;
          if (rx_cnt == RX_LAST) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_good) begin
            cmd_valid <= 1'b1;
            cmd_index <= rx_frame[IDX_HI:IDX_LO];
            cmd_arg   <= rx_frame[ARG_HI:ARG_LO];
            tx_shift  <= {2'b00, rx_frame[IDX_HI:IDX_LO], card_status};
            wait_cnt  <= '0;
            state     <= (rx_frame[IDX_HI:IDX_LO] == 6'd0) ? ST_IDLE : ST_WAIT_NCR;
          end else begin
            crc_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WAIT_NCR: begin
          if (start_send) begin
            state          <= ST_SEND;
            cmd_to_host_oe <= 1'b1;
            cmd_to_host    <= tx_shift[CRC_SPAN-1];
            tx_shift       <= {tx_shift[CRC_SPAN-2:0], 1'b0};
            tx_cnt         <= 6'd1;
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
        end
        ST_SEND: begin
          if (tx_cnt == TX_DONE) begin
            state          <= ST_IDLE;
            cmd_to_host_oe <= 1'b0;
            cmd_to_host    <= 1'b1;
          end else begin
            cmd_to_host <= tx_bit;
            tx_cnt      <= tx_cnt + 6'd1;
            if (tx_cnt < TX_CRC_START) begin
              tx_shift <= {tx_shift[CRC_SPAN-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_card_cmd_responder.md
SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 The module SHALL have parameter NCR, default 2, meaning the number of idle cycles between the CHECK cycle and the response start bit (legal range 1..64).
REQ-002 The module SHALL have port CLK, input, 1, the single clock (card clock domain); all logic is rising-edge.
REQ-003 The module SHALL have port RESET, input, 1, reset that is asynchronous and active-high.
REQ-004 The module SHALL have port cmd_from_host, input, 1, the serial CMD line from the host, sampled every rising edge.
REQ-005 The module SHALL have port card_status, input, 32, the R1 status word returned in responses.
REQ-006 The module SHALL have port cmd_to_host, output, 1, the serial response bit.
REQ-007 The module SHALL have port cmd_to_host_oe, output, 1, high while the response is driven.
REQ-008 The module SHALL have port cmd_valid, output, 1, a one-cycle pulse when a good command is received.
REQ-009 The module SHALL have port cmd_index, output, 6, the latched command index.
REQ-010 The module SHALL have port cmd_arg, output, 32, the latched command argument.
REQ-011 The module SHALL have port crc_error, output, 1, a one-cycle pulse when a received frame is bad.

Function
REQ-012 The module SHALL implement FSM states IDLE, RECV, CHECK, WAIT_NCR and SEND.
REQ-013 The module SHALL use a 48-bit command frame, transmitted MSB first: start 0, transmission bit 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
REQ-014 In IDLE, sampling cmd_from_host=0 SHALL count that bit as frame bit 47 and transition to RECV; a sample of 1 SHALL keep the FSM in IDLE.
REQ-015 RECV SHALL shift in the remaining 47 bits, one per cycle, with a 6-bit counter, and enter CHECK on the cycle after the end bit is sampled.
REQ-016 CHECK SHALL last exactly 1 cycle and declare the frame good only if the transmission bit=1, the end bit=1, and the CRC7 (G=x^7+x^3+1, initial value 0) computed over the first 40 bits equals the received CRC.
REQ-017 On a good frame, CHECK SHALL pulse cmd_valid for that cycle, load cmd_index/cmd_arg, and capture card_status into the response shift register.
REQ-018 On a good frame with index 0 (CMD0), the FSM SHALL go CHECK→IDLE with no response; other indices SHALL go CHECK→WAIT_NCR.
REQ-019 On a bad frame, CHECK SHALL pulse crc_error, leave cmd_index/cmd_arg unchanged, go to IDLE, and send no response.
REQ-020 WAIT_NCR SHALL hold cmd_to_host_oe=0 and cmd_to_host=1 for NCR cycles, then enter SEND.
REQ-021 SEND SHALL drive a 48-bit R1 frame for 48 consecutive cycles with oe=1: 0, 0, cmd_index, captured status, CRC7 over those 40 bits, 1.
REQ-022 The cycle after the end bit, the FSM SHALL be in IDLE with oe=0, and a start bit sampled in that cycle SHALL be accepted.
REQ-023 cmd_from_host SHALL be ignored in CHECK, WAIT_NCR and SEND; a host start bit there is lost without error.
REQ-024 A changing card_status after CHECK SHALL NOT affect the response in flight.
REQ-025 All outputs SHALL be registered.
REQ-026 Latency SHALL be 49 cycles from the start-bit sample to cmd_valid, and 49+NCR cycles to the response start bit.

Reset
REQ-027 Asserting RESET SHALL immediately force the FSM to IDLE, cmd_to_host=1, cmd_to_host_oe=0, cmd_valid=0, crc_error=0, cmd_index=0, cmd_arg=0, and clear the counters and CRC state.
REQ-028 RESET asserted mid-RECV or mid-SEND SHALL abort the frame with no pulse, and after release the FSM SHALL wait for a fresh start bit.

Structure
REQ-029 The frame length (48), CRC7 polynomial, field bit positions and state encodings SHALL live in the shared defines.v.
REQ-030 The serial CRC7 SHALL be a sub-module sd_crc7_serial (inputs: clear, enable, bit; output: crc[6:0]), instantiated once for RX and once for TX.

Verification
REQ-031 Frame 40 00 00 00 00 95 (CMD0) -> one cmd_valid pulse, cmd_index=0, cmd_arg=0, and oe never asserted.
REQ-032 Frame 51 00 00 00 00 55 (CMD17), card_status=0x00000900, NCR=2 -> cmd_valid at cycle 49, oe rising at cycle 51, and response bytes 11 00 00 09 00 67.
REQ-033 Frame 77 00 00 00 00 64 (bad CRC; correct is 65) -> one crc_error pulse, no cmd_valid, oe stays 0, and cmd_index keeps its previous value.
REQ-034 Back-to-back: send CMD55 (77 00 00 00 00 65), then drive CMD17 starting the cycle after the response end bit -> both are accepted with two responses, and a start bit injected during SEND is ignored.
REQ-035 RESET pulsed at response bit 20 -> oe drops asynchronously and cmd_to_host=1; a following CMD17 gets a correct full response.
REQ-036 Random index/argument with a reference CRC model over 1000 frames, including frames with one flipped bit -> every flipped frame yields crc_error and every clean frame yields a bit-exact response.
